cnn_argmax: RTL and testbench
=============================

// Module: cnn_argmax
// PURPOSE
//  Output-stage classifier directly downstream of the CNN top. Consumes the NUM_CLASSES quantized
//  logits of the final dense layer in one ready/valid beat, scans them serially (one class per cycle)
//  and returns the winning class index plus its score, with a ready/valid output handshake.
//  Also keeps a wrapping count of completed predictions for on-board debug.
// PARAMETERS
//  NUM_CLASSES   10   number of logits per prediction (>=1)
//  DATA_W        8    logit width (= FEATURE_MAP_RESOLUTION)
//  SIGNED_DATA   1    1: logits compared as two's complement; 0: unsigned
//  CLASS_W       $clog2(NUM_CLASSES) (min 1)  width of class index (derived, localparam)
//  CNT_W         16   prediction counter width
// PORTS
//  clk_i          in   1                  clock; single clock domain
//  rst_i          in   1                  asynchronous reset, active-high
//  in_valid_i     in   1                  logit vector valid
//  in_data_i      in   DATA_W x NUM_CLASSES  logits [0:NUM_CLASSES-1]
//  in_ready_o     out  1                  block can accept a vector
//  out_valid_o    out  1                  result valid
//  out_class_o    out  CLASS_W            index of maximum logit
//  out_score_o    out  DATA_W             value of maximum logit
//  out_ready_i    in   1                  downstream accepts result
//  pred_count_o   out  CNT_W              completed output handshakes, wraps 2^CNT_W-1 -> 0
// BEHAVIOUR
//  Reset (async assert, sync-free deassert use): state=IDLE, in_ready_o=0 during rst_i then 1 in IDLE,
//   out_valid_o=0, out_class_o=0, out_score_o=0, pred_count_o=0, internal vector/index/counter cleared.
//  FSM: IDLE -> SCAN -> DONE -> IDLE.
//   IDLE: in_ready_o=1. On in_valid_i&&in_ready_o: register full vector, best<=data[0], idx<=0,
//    ptr<=1; go SCAN (NUM_CLASSES>=2) or DONE directly (NUM_CLASSES==1).
//   SCAN: in_ready_o=0. Each cycle compare vec[ptr] vs best; if strictly greater, best<=vec[ptr],
//    idx<=ptr. ptr increments; after ptr==NUM_CLASSES-1 is compared go DONE.
//   DONE: out_valid_o=1, out_class_o/out_score_o stable, in_ready_o=0. On out_ready_i: out_valid_o
//    drops next cycle, pred_count_o increments, go IDLE. Results held indefinitely under backpressure.
//  Latency: accept at edge T -> out_valid_o high after edge T+NUM_CLASSES-1 (NUM_CLASSES>=2),
//   after edge T for NUM_CLASSES==1. Throughput: one vector per NUM_CLASSES+1 cycles with out_ready_i=1.
//  Ties: lowest index wins (strict > comparison). Signedness per SIGNED_DATA ($signed compare).
//  in_data_i only sampled on the accept edge; changes afterwards do not affect the result.
//  in_valid_i while busy is ignored (no accept, no error); upstream must hold it per valid/ready rule.
//  No combinational path from in_valid_i to in_ready_o or out_ready_i to out_valid_o.
//  rst_i mid-SCAN or mid-DONE: in-flight vector discarded, no output, pred_count_o returns to 0.
//  out_class_o/out_score_o keep last result after handshake until next DONE (don't-care while invalid).
// TESTING (NUM_CLASSES=10, DATA_W=8, SIGNED_DATA=1)
//  1 logits {-5,3,7,-128,0,2,7,1,-1,6}, out_ready_i=1 -> class 2, score 7 (tie with idx 6), out_valid_o
//    rises 9 cycles after accept, pred_count_o=1.
//  2 all logits -128 -> class 0, score 0x80; repeat with SIGNED_DATA=0 and logit[9]=0x80,others 0x7F
//    -> class 9, score 0x80.
//  3 out_ready_i=0 for 20 cycles at DONE -> out_valid_o,class,score stable, in_ready_o=0, second
//    in_valid_i not accepted; release -> one handshake, pred_count_o +1 only.
//  4 back-to-back vectors, max at idx 9 then idx 0, ready=1 -> results 9 then 0 in order, 11-cycle
//    period, in_data_i changed during SCAN has no effect.
//  5 assert rst_i 4 cycles into SCAN -> all outputs 0 immediately; after release in_ready_o=1 and next
//    vector {0..9} gives class 9, score 9.
//  6 force pred_count_o to 0xFFFF region (65536 predictions or preload via test hook) -> wraps to 0.

Source files
------------

// File: rtl/cnn_argmax.sv
// Output-stage argmax for the CNN: takes one logit vector per handshake, scans it one class
// per cycle and presents the winning class index and score with a ready/valid handshake.
module cnn_argmax #(
    parameter  int NUM_CLASSES = 10,
    parameter  int DATA_W      = 8,
    parameter  int SIGNED_DATA = 1,
    parameter  int CNT_W       = 16,
    localparam int CLASS_W     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          in_valid_i,
    input  logic [NUM_CLASSES*DATA_W-1:0] in_data_i,
    output logic                          in_ready_o,
    output logic                          out_valid_o,
    output logic [CLASS_W-1:0]            out_class_o,
    output logic [DATA_W-1:0]             out_score_o,
    input  logic                          out_ready_i,
    output logic [CNT_W-1:0]              pred_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASSES - 1);

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   in_logit [NUM_CLASSES];
    logic [DATA_W-1:0]   vec_reg  [NUM_CLASSES];
    logic [DATA_W-1:0]   best_reg, best_next;
    logic [CLASS_W-1:0]  idx_reg, idx_next;
    logic [CLASS_W-1:0]  ptr_reg, ptr_next;
    logic [CLASS_W-1:0]  class_reg, class_next;
    logic [DATA_W-1:0]   score_reg, score_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                load_vec;
    logic                ready_int;
    logic                valid_int;
    logic [DATA_W-1:0]   cand;
    logic                cand_gt;

    // Logit k occupies bits [k*DATA_W +: DATA_W] of the flat input bus.
    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_vec
            assign in_logit[gi] = in_data_i[gi*DATA_W +: DATA_W];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    vec_reg[gi] <= '0;
                end else if (load_vec) begin
                    vec_reg[gi] <= in_logit[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        cand = vec_reg[ptr_reg];
        if (SIGNED_DATA != 0) begin
            cand_gt = $signed(cand) > $signed(best_reg);
        end else begin
            cand_gt = cand > best_reg;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            best_reg  <= '0;
            idx_reg   <= '0;
            ptr_reg   <= '0;
            class_reg <= '0;
            score_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            best_reg  <= best_next;
            idx_reg   <= idx_next;
            ptr_reg   <= ptr_next;
            class_reg <= class_next;
            score_reg <= score_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        best_next  = best_reg;
        idx_next   = idx_reg;
        ptr_next   = ptr_reg;
        class_next = class_reg;
        score_next = score_reg;
        cnt_next   = cnt_reg;
        load_vec   = 1'b0;
        ready_int  = 1'b0;
        valid_int  = 1'b0;

        case (state_reg)
            IDLE: begin
                ready_int = 1'b1;
                if (in_valid_i) begin
                    load_vec  = 1'b1;
                    best_next = in_logit[0];
                    idx_next  = '0;
                    ptr_next  = CLASS_W'(1);
                    if (NUM_CLASSES > 1) begin
                        state_next = SCAN;
                    end else begin
                        class_next = '0;
                        score_next = in_logit[0];
                        state_next = DONE;
                    end
                end
            end
            SCAN: begin
                // Strict comparison keeps the lowest index on ties.
                if (cand_gt) begin
                    best_next = cand;
                    idx_next  = ptr_reg;
                end
                ptr_next = ptr_reg + CLASS_W'(1);
                if (ptr_reg == LAST_IDX) begin
                    class_next = cand_gt ? ptr_reg : idx_reg;
                    score_next = cand_gt ? cand : best_reg;
                    state_next = DONE;
                end
            end
            DONE: begin
                valid_int = 1'b1;
                if (out_ready_i) begin
                    cnt_next   = cnt_reg + CNT_W'(1);
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Ready is held low for as long as reset is asserted, even though the state already reads IDLE.
    assign in_ready_o   = ready_int & ~rst_i;
    assign out_valid_o  = valid_int;
    assign out_class_o  = class_reg;
    assign out_score_o  = score_reg;
    assign pred_count_o = cnt_reg;

endmodule

// File: tb/tb_cnn_argmax.sv
// Bench for cnn_argmax: an argmax reference model checks the main instance every cycle; two
// extra instances cover unsigned compare and the single-class / counter-wrap corner.
module tb_cnn_argmax;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0;
    logic [79:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out_class;
    logic [7:0]  out_score;
    logic        out_ready = 1'b1;
    logic [15:0] pred_count;

    logic        u_in_valid = 1'b0;
    logic [79:0] u_in_data = '0;
    logic        u_in_ready;
    logic        u_out_valid;
    logic [3:0]  u_out_class;
    logic [7:0]  u_out_score;
    logic        u_out_ready = 1'b1;
    logic [15:0] u_pred_count;

    logic        s_in_valid = 1'b0;
    logic [7:0]  s_in_data = '0;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [0:0]  s_out_class;
    logic [7:0]  s_out_score;
    logic        s_out_ready = 1'b1;
    logic [3:0]  s_pred_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnn_argmax #(.NUM_CLASSES(10), .DATA_W(8), .SIGNED_DATA(1), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(in_ready), .out_valid_o(out_valid), .out_class_o(out_class),
        .out_score_o(out_score), .out_ready_i(out_ready), .pred_count_o(pred_count)
    );

    cnn_argmax #(.NUM_CLASSES(10), .DATA_W(8), .SIGNED_DATA(0), .CNT_W(16)) dut_u (
        .clk_i(clk), .rst_i(rst), .in_valid_i(u_in_valid), .in_data_i(u_in_data),
        .in_ready_o(u_in_ready), .out_valid_o(u_out_valid), .out_class_o(u_out_class),
        .out_score_o(u_out_score), .out_ready_i(u_out_ready), .pred_count_o(u_pred_count)
    );

    cnn_argmax #(.NUM_CLASSES(1), .DATA_W(8), .SIGNED_DATA(0), .CNT_W(4)) dut_1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(s_in_valid), .in_data_i(s_in_data),
        .in_ready_o(s_in_ready), .out_valid_o(s_out_valid), .out_class_o(s_out_class),
        .out_score_o(s_out_score), .out_ready_i(s_out_ready), .pred_count_o(s_pred_count)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [79:0] pack(input int v [10]);
        logic [79:0] r;
        r = '0;
        for (int k = 0; k < 10; k++) r[k*8 +: 8] = 8'(v[k]);
        return r;
    endfunction

    // Reference: find the maximum value, then the first index holding it.
    function automatic void ref_argmax(input logic [79:0] d, input bit sgn,
                                       output int c, output logic [7:0] s);
        int vals [10];
        int maxv;
        for (int k = 0; k < 10; k++)
            vals[k] = sgn ? int'($signed(d[k*8 +: 8])) : int'(d[k*8 +: 8]);
        maxv = vals[0];
        foreach (vals[k]) if (vals[k] > maxv) maxv = vals[k];
        c = 0;
        for (int k = 9; k >= 0; k--) if (vals[k] == maxv) c = k;
        s = d[c*8 +: 8];
    endfunction

    // Model state for the main instance.
    bit          m_pending = 1'b0;
    int          m_wait = 0;
    int          m_class = 0;
    logic [7:0]  m_score = '0;
    int          p_class = 0;
    logic [7:0]  p_score = '0;
    int          m_count = 0;
    int          cyc = 0;
    int          fire_log [$];
    int          accept_cyc [$];

    always @(negedge clk) begin
        bit exp_v;
        cyc++;
        if (rst) begin
            m_pending = 1'b0;
            m_wait    = 0;
            m_class   = 0;
            m_score   = '0;
            m_count   = 0;
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_class", out_class, 0);
            chk("rst_score", out_score, 0);
            chk("rst_count", pred_count, 0);
        end else begin
            exp_v = m_pending && (m_wait == 0);
            chk("in_ready", in_ready, !m_pending);
            chk("out_valid", out_valid, exp_v);
            chk("out_class", out_class, m_class);
            chk("out_score", out_score, m_score);
            chk("pred_count", pred_count, m_count);
            if (m_pending && m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_class = p_class;
                    m_score = p_score;
                end
            end
            if (exp_v && out_ready) begin
                m_pending = 1'b0;
                m_count   = (m_count + 1) % 65536;
                fire_log.push_back(m_class);
            end else if (in_valid && !m_pending) begin
                m_pending = 1'b1;
                m_wait    = 9;
                ref_argmax(in_data, 1'b1, p_class, p_score);
                accept_cyc.push_back(cyc);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send_vec(input logic [79:0] d);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts clock edges after the accept edge until out_valid is seen; returns at a negedge.
    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        int vv [10];
        int lat, c0, n0, na, t;

        repeat (3) @(negedge clk);
        chk("rst_u_ready", u_in_ready, 0);
        chk("rst_s_ready", s_in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_count", pred_count, 0);
        @(posedge clk);
        #1;

        // Tie between idx 2 and 6 resolves to 2.
        vv = '{-5, 3, 7, -128, 0, 2, 7, 1, -1, 6};
        send_vec(pack(vv));
        wait_valid(lat);
        chk("t1_latency", lat, 9);
        chk("t1_class", out_class, 2);
        chk("t1_score", out_score, 7);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t1_count", pred_count, 1);
        chk("t1_valid_drop", out_valid, 0);
        @(posedge clk);
        #1;

        vv = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
        send_vec(pack(vv));
        wait_valid(lat);
        chk("t2_class", out_class, 0);
        chk("t2_score", out_score, 8'h80);
        @(posedge clk);
        #1;

        // Signed view of 0x80 is the minimum, so idx 0 wins with 0x7F.
        vv = '{127, 127, 127, 127, 127, 127, 127, 127, 127, 128};
        send_vec(pack(vv));
        wait_valid(lat);
        chk("t2s_class", out_class, 0);
        chk("t2s_score", out_score, 8'h7F);
        @(posedge clk);
        #1;

        // Backpressure in DONE with a competing vector offered.
        out_ready = 1'b0;
        vv = '{10, 20, -3, 50, 4, 50, 0, 0, 0, -1};
        send_vec(pack(vv));
        wait_valid(lat);
        c0 = pred_count;
        @(posedge clk);
        #1;
        vv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 99};
        in_data  = pack(vv);
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("t3_valid", out_valid, 1);
            chk("t3_class", out_class, 3);
            chk("t3_score", out_score, 50);
            chk("t3_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_count", pred_count, c0 + 1);
        chk("t3_valid_drop", out_valid, 0);
        repeat (3) @(negedge clk);
        chk("t3_count_hold", pred_count, c0 + 1);
        @(posedge clk);
        #1;

        // Back-to-back vectors; input bus changes while scanning.
        n0 = fire_log.size();
        na = accept_cyc.size();
        vv = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 100};
        in_data  = pack(vv);
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        @(posedge clk);
        #1;
        vv = '{90, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        in_data = pack(vv);
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vv = '{127, 127, 127, 127, 127, 127, 127, 127, 127, 127};
        in_data = pack(vv);
        t = 0;
        while (fire_log.size() < n0 + 2 && t < 100) begin @(negedge clk); t++; end
        if (fire_log.size() < n0 + 2) begin
            chk("t4_timeout", 0, 1);
        end else begin
            chk("t4_first", fire_log[n0], 9);
            chk("t4_second", fire_log[n0+1], 0);
            chk("t4_period", accept_cyc[na+1] - accept_cyc[na], 11);
        end
        @(posedge clk);
        #1;

        // Reset in the middle of a scan.
        vv = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
        send_vec(pack(vv));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_valid", out_valid, 0);
        chk("t5_class", out_class, 0);
        chk("t5_score", out_score, 0);
        chk("t5_count", pred_count, 0);
        chk("t5_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_ready_after", in_ready, 1);
        @(posedge clk);
        #1;
        vv = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        send_vec(pack(vv));
        wait_valid(lat);
        chk("t5_latency", lat, 9);
        chk("t5b_class", out_class, 9);
        chk("t5b_score", out_score, 9);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5b_count", pred_count, 1);
        @(posedge clk);
        #1;

        // Unsigned instance: 0x80 beats 0x7F.
        vv = '{127, 127, 127, 127, 127, 127, 127, 127, 127, 128};
        u_in_data  = pack(vv);
        u_in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!u_in_ready && t < 100) begin @(negedge clk); t++; end
        chk("u_accept", u_in_ready, 1);
        @(posedge clk);
        #1;
        u_in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!u_out_valid && lat < 100) begin @(negedge clk); lat++; end
        chk("u_latency", lat, 9);
        chk("u_class", u_out_class, 9);
        chk("u_score", u_out_score, 8'h80);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("u_count", u_pred_count, 1);
        @(posedge clk);
        #1;

        // Single-class instance: one-edge latency and 4-bit counter wrap.
        for (int k = 0; k < 17; k++) begin
            s_in_data  = 8'(k * 3);
            s_in_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!s_in_ready && t < 100) begin @(negedge clk); t++; end
            @(posedge clk);
            #1;
            s_in_valid = 1'b0;
            @(negedge clk);
            chk("s_valid", s_out_valid, 1);
            chk("s_score", s_out_score, (k * 3) % 256);
            chk("s_class", s_out_class, 0);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("s_count", s_pred_count, (k + 1) % 16);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
